// File: rtl/viterbi_pkg.sv
// Shared trellis parameters and traceback FSM encoding for the Viterbi decoder stages
// (ACS, path memory and traceback all import this package).
package viterbi_pkg;
  localparam int NUM_ST_DEF   = 4;
  localparam int ST_W_DEF     = 2;
  localparam int TB_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    TB_IDLE  = 2'd0,
    TB_TRACE = 2'd1,
    TB_EMIT  = 2'd2
  } tb_state_e;
endpackage

// File: rtl/viterbi_lifo.sv
// Single-bit LIFO that reverses traced bits into forward time order.
// The pointer saturates at both ends, so a push when full or a pop when empty is dropped.
module viterbi_lifo
  import viterbi_pkg::*;
#(
  parameter int DEPTH = TB_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);

  // dout_o is the top of stack; it reads 0 when the stack is empty.
  always_comb begin
    mem_d  = mem_q;
    ptr_d  = ptr_q;
    dout_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ptr_q == PW'(i + 1)) dout_o = mem_q[i];
    if (push_i && !full_o) begin
      for (int i = 0; i < DEPTH; i++)
        if (ptr_q == PW'(i)) mem_d[i] = din_i;
      ptr_d = ptr_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: follows back-pointers over a TB_DEPTH window and emits bits in forward order.
// Optional parallel word output is enabled by defining VITERBI_TB_PAR_OUT_EN.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int NUM_ST   = NUM_ST_DEF,
  parameter int ST_W     = ST_W_DEF,
  parameter int TB_DEPTH = TB_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_t,
  input  logic                   i_bck_vld,
  input  logic [NUM_ST*ST_W-1:0] i_bck_prv_st,
  input  logic [ST_W-1:0]        i_start_st,
  output logic                   o_busy,
  output logic                   o_bit,
  output logic                   o_bit_vld,
  output logic                   o_done
`ifdef VITERBI_TB_PAR_OUT_EN
  ,
  output logic [TB_DEPTH-1:0]    o_word,
  output logic                   o_word_vld
`endif
);
  localparam int CNT_W = $clog2(TB_DEPTH + 1);

  tb_state_e       state_q, state_d;
  logic [ST_W-1:0] cur_st_q, cur_st_d;
  logic [ST_W-1:0] sel_st, nxt_st;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            last_bit_q, last_bit_d;
  logic            accept, pop;
  logic            lifo_top, lifo_full, lifo_empty;

  // The first step of a window traces from the supplied start state; later ones from cur_st.
  assign sel_st = (state_q == TB_IDLE) ? i_start_st : cur_st_q;

  always_comb begin
    nxt_st = '0;
    for (int s = 0; s < NUM_ST; s++)
      if (sel_st == ST_W'(s)) nxt_st = i_bck_prv_st[s*ST_W +: ST_W];
  end

  assign accept = en_t & i_bck_vld & (state_q != TB_EMIT) & ~lifo_full;
  assign pop    = en_t & (state_q == TB_EMIT) & ~lifo_empty;

  always_comb begin
    state_d    = state_q;
    cur_st_d   = cur_st_q;
    cnt_d      = cnt_q;
    last_bit_d = last_bit_q;
    o_bit_vld  = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      TB_IDLE, TB_TRACE: begin
        if (accept) begin
          cur_st_d = nxt_st;
          if (cnt_q == CNT_W'(TB_DEPTH - 1)) begin
            cnt_d   = CNT_W'(TB_DEPTH);
            state_d = TB_EMIT;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = TB_TRACE;
          end
        end
      end
      TB_EMIT: begin
        if (pop) begin
          o_bit_vld  = 1'b1;
          last_bit_d = lifo_top;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            o_done  = 1'b1;
            state_d = TB_IDLE;
          end
        end
      end
      default: state_d = TB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TB_IDLE;
      cur_st_q   <= '0;
      cnt_q      <= '0;
      last_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_st_q   <= cur_st_d;
      cnt_q      <= cnt_d;
      last_bit_q <= last_bit_d;
    end
  end

  // o_bit keeps showing the last emitted bit whenever nothing is popped.
  assign o_bit  = pop ? lifo_top : last_bit_q;
  assign o_busy = (state_q == TB_EMIT);

  viterbi_lifo #(.DEPTH(TB_DEPTH)) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (sel_st[ST_W-1]),
    .dout_o  (lifo_top),
    .full_o  (lifo_full),
    .empty_o (lifo_empty)
  );

`ifdef VITERBI_TB_PAR_OUT_EN
  logic [TB_DEPTH-1:0] word_q, word_d;

  // Bits pop step 0 first and shift down, so step i lands in bit i after the last pop.
  assign word_d = pop ? {lifo_top, word_q[TB_DEPTH-1:1]} : word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign o_word     = word_d;
  assign o_word_vld = o_done;
`endif
endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback; expected bits are queued as each window is driven.
module tb_viterbi_traceback;
  localparam int TBD = 8;

  logic       clk = 1'b0;
  logic       rst, en_t, i_bck_vld;
  logic [7:0] i_bck_prv_st;
  logic [1:0] i_start_st;
  logic       o_busy, o_bit, o_bit_vld, o_done;
`ifdef VITERBI_TB_PAR_OUT_EN
  logic [TBD-1:0] o_word;
  logic           o_word_vld;
`endif

  int checks = 0;
  int failures = 0;
  logic     exp_q[$];
  logic [TBD-1:0] exp_word;

  always #5 clk = ~clk;

  viterbi_traceback dut (
    .clk          (clk),
    .rst          (rst),
    .en_t         (en_t),
    .i_bck_vld    (i_bck_vld),
    .i_bck_prv_st (i_bck_prv_st),
    .i_start_st   (i_start_st),
    .o_busy       (o_busy),
    .o_bit        (o_bit),
    .o_bit_vld    (o_bit_vld),
    .o_done       (o_done)
`ifdef VITERBI_TB_PAR_OUT_EN
    ,
    .o_word       (o_word),
    .o_word_vld   (o_word_vld)
`endif
  );

  // Drives nsteps back-pointer steps (newest first) and returns the traced word, bit i = step i.
  task automatic drive_steps(input logic [7:0] prv, input logic [1:0] start, input int nsteps,
                             input bit gaps, input bit rnd, output logic [TBD-1:0] w);
    logic [1:0] cur;
    logic [7:0] p;
    cur = start;
    w   = '0;
    for (int k = 0; k < nsteps; k++) begin
      if (gaps && (rnd ? ($urandom_range(0, 1) == 1) : (k % 3 == 1))) begin
        @(negedge clk);
        i_bck_vld = 1'b0; i_bck_prv_st = 8'($urandom); i_start_st = 2'($urandom);
      end
      p = rnd ? 8'($urandom) : prv;
      @(negedge clk);
      i_bck_vld = 1'b1; i_bck_prv_st = p;
      i_start_st = (k == 0) ? start : ~start;
      w[TBD-1-k] = cur[1];
      cur = p[cur*2 +: 2];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_t = 1'b1; i_bck_vld = 1'b0; i_bck_prv_st = '0; i_start_st = '0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_bit !== 1'b0 || o_bit_vld !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b bit=%b vld=%b done=%b want 0 0 0 0", o_busy, o_bit, o_bit_vld, o_done);
    end
`ifdef VITERBI_TB_PAR_OUT_EN
    checks++;
    if (o_word !== '0 || o_word_vld !== 1'b0) begin
      failures++; $display("FAIL reset_word: word=%h vld=%b want 00 0", o_word, o_word_vld);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    logic [7:0]     prv_t [3];
    logic [1:0]     st_t  [3];
    logic [TBD-1:0] wd_t  [3];
    logic [TBD-1:0] w;
    logic e;
    int ndone;
    prv_t = '{8'h00, 8'hC0, 8'h18};
    st_t  = '{2'd0, 2'd3, 2'd2};
    wd_t  = '{8'h00, 8'hFF, 8'hAA};
    for (int t = 0; t < 3; t++) begin
      drive_steps(prv_t[t], st_t[t], TBD, 1'b0, 1'b0, w);
      for (int i = 0; i < TBD; i++) exp_q.push_back(wd_t[t][i]);
      exp_word = wd_t[t];
      ndone = 0;
      for (int c = 0; c < TBD + 4 && ndone == 0; c++) begin
        @(negedge clk); i_bck_vld = 1'b0; #1;
        if (c == 0) begin
          checks++;
          if (o_bit_vld !== 1'b1 || o_busy !== 1'b1) begin
            failures++; $display("FAIL latency pat%0d: vld=%b busy=%b want 1 1", t, o_bit_vld, o_busy);
          end
        end
        if (o_bit_vld === 1'b1) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
          checks++;
          if (o_bit !== e || o_done !== (exp_q.size() == 0)) begin
            failures++;
            $display("FAIL pat%0d bit: o_bit=%b o_done=%b want %b %b", t, o_bit, o_done, e, exp_q.size() == 0);
          end
`ifdef VITERBI_TB_PAR_OUT_EN
          if (o_done) begin
            checks++;
            if (o_word !== exp_word || o_word_vld !== 1'b1) begin
              failures++; $display("FAIL pat%0d word: %h vld=%b want %h 1", t, o_word, o_word_vld, exp_word);
            end
          end
`endif
          if (o_done) ndone++;
        end
      end
      checks++;
      if (ndone != 1 || exp_q.size() != 0) begin
        failures++; $display("FAIL pat%0d window: dones=%0d left=%0d want 1 0", t, ndone, exp_q.size());
      end
      exp_q.delete();
    end
  endtask

  task automatic test_gaps_freeze();
    logic [TBD-1:0] w;
    logic e;
    int ndone;
    drive_steps(8'h18, 2'd2, TBD, 1'b1, 1'b0, w);
    for (int i = 0; i < TBD; i++) exp_q.push_back(w[i]);
    ndone = 0;
    for (int c = 0; c < TBD + 8 && ndone == 0; c++) begin
      @(negedge clk); i_bck_vld = 1'b0; en_t = !(c >= 2 && c < 5); #1;
      if (!en_t) begin
        checks++;
        if (o_bit_vld !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
          failures++; $display("FAIL freeze: vld=%b done=%b busy=%b want 0 0 1", o_bit_vld, o_done, o_busy);
        end
      end
      if (o_bit_vld === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        checks++;
        if (o_bit !== e || o_done !== (exp_q.size() == 0)) begin
          failures++; $display("FAIL gaps bit: o_bit=%b o_done=%b want %b %b", o_bit, o_done, e, exp_q.size() == 0);
        end
        if (o_done) ndone++;
      end
    end
    en_t = 1'b1;
    checks++;
    if (ndone != 1 || exp_q.size() != 0 || w !== 8'hAA) begin
      failures++; $display("FAIL gaps window: dones=%0d left=%0d word=%h want 1 0 aa", ndone, exp_q.size(), w);
    end
    exp_q.delete();
  endtask

  task automatic test_rst_mid();
    logic [TBD-1:0] w;
    logic e;
    int ndone, nvld;
    drive_steps(8'hFF, 2'd3, 5, 1'b0, 1'b0, w);
    @(negedge clk); i_bck_vld = 1'b0; rst = 1'b1; #1;
    checks++;
    if (o_busy !== 1'b0 || o_bit_vld !== 1'b0) begin
      failures++; $display("FAIL rst_trace: busy=%b vld=%b want 0 0", o_busy, o_bit_vld);
    end
    @(negedge clk); rst = 1'b0;
    drive_steps(8'hC0, 2'd3, TBD, 1'b0, 1'b0, w);
    repeat (3) begin @(negedge clk); i_bck_vld = 1'b0; end
    rst = 1'b1; #1;
    checks++;
    if (o_busy !== 1'b0 || o_bit_vld !== 1'b0 || o_done !== 1'b0) begin
      failures++; $display("FAIL rst_emit: busy=%b vld=%b done=%b want 0 0 0", o_busy, o_bit_vld, o_done);
    end
    @(negedge clk); rst = 1'b0;
    drive_steps(8'h00, 2'd0, TBD, 1'b0, 1'b0, w);
    for (int i = 0; i < TBD; i++) exp_q.push_back(1'b0);
    ndone = 0; nvld = 0;
    for (int c = 0; c < TBD + 6; c++) begin
      @(negedge clk); i_bck_vld = 1'b0; #1;
      if (o_bit_vld === 1'b1) begin
        nvld++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        checks++;
        if (o_bit !== e || o_done !== (exp_q.size() == 0)) begin
          failures++; $display("FAIL rst_fresh bit: o_bit=%b o_done=%b want %b %b", o_bit, o_done, e, exp_q.size() == 0);
        end
      end
      if (o_done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 1 || nvld != TBD) begin
      failures++; $display("FAIL rst_fresh window: dones=%0d bits=%0d want 1 %0d", ndone, nvld, TBD);
    end
    exp_q.delete();
  endtask

  task automatic test_vld_in_emit();
    logic [TBD-1:0] w;
    logic e;
    int ndone;
    for (int t = 0; t < 2; t++) begin
      drive_steps(t == 0 ? 8'h18 : 8'h00, t == 0 ? 2'd2 : 2'd0, TBD, 1'b0, 1'b0, w);
      for (int i = 0; i < TBD; i++) exp_q.push_back(t == 0 ? (i % 2 == 1) : 1'b0);
      ndone = 0;
      for (int c = 0; c < TBD + 4 && ndone == 0; c++) begin
        @(negedge clk);
        i_bck_vld = (t == 0); i_bck_prv_st = 8'($urandom); i_start_st = 2'($urandom); #1;
        if (o_bit_vld === 1'b1) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
          checks++;
          if (o_bit !== e || o_done !== (exp_q.size() == 0)) begin
            failures++; $display("FAIL vld_emit%0d bit: o_bit=%b o_done=%b want %b %b", t, o_bit, o_done, e, exp_q.size() == 0);
          end
          if (o_done) ndone++;
        end
      end
      @(negedge clk); i_bck_vld = 1'b0; #1;
      checks++;
      if (ndone != 1 || exp_q.size() != 0 || o_busy !== 1'b0) begin
        failures++; $display("FAIL vld_emit%0d window: dones=%0d left=%0d busy=%b want 1 0 0", t, ndone, exp_q.size(), o_busy);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_random();
    logic [TBD-1:0] w;
    logic e;
    int ndone;
    for (int t = 0; t < 4; t++) begin
      drive_steps(8'h00, 2'($urandom), TBD, 1'b1, 1'b1, w);
      for (int i = 0; i < TBD; i++) exp_q.push_back(w[i]);
      exp_word = w;
      ndone = 0;
      for (int c = 0; c < TBD + 4 && ndone == 0; c++) begin
        @(negedge clk); i_bck_vld = 1'b0; #1;
        if (o_bit_vld === 1'b1) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
          checks++;
          if (o_bit !== e || o_done !== (exp_q.size() == 0)) begin
            failures++; $display("FAIL rand%0d bit: o_bit=%b o_done=%b want %b %b", t, o_bit, o_done, e, exp_q.size() == 0);
          end
`ifdef VITERBI_TB_PAR_OUT_EN
          if (o_done) begin
            checks++;
            if (o_word !== exp_word) begin
              failures++; $display("FAIL rand%0d word: %h want %h", t, o_word, exp_word);
            end
          end
`endif
          if (o_done) ndone++;
        end
      end
      checks++;
      if (ndone != 1 || exp_q.size() != 0) begin
        failures++; $display("FAIL rand%0d window: dones=%0d left=%0d want 1 0", t, ndone, exp_q.size());
      end
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_gaps_freeze();
    test_rst_mid();
    test_vld_in_emit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/viterbi_traceback.md
VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

Interface
REQ-001 SHALL have parameter NUM_ST, default 4, number of trellis states (K=3, radix-2).
REQ-002 SHALL have parameter ST_W, default 2, state index width (log2 NUM_ST).
REQ-003 SHALL have parameter TB_DEPTH, default 8, trellis steps per traceback window.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en_t  input  1  stage enable; low freezes all state and outputs.
REQ-007 SHALL have port i_bck_vld  input  1  one trellis step of back-pointers present this cycle.
REQ-008 SHALL have port i_bck_prv_st  input  NUM_ST*ST_W  back-pointer per state; slice s is the predecessor of state s. Steps arrive newest first (step TB_DEPTH-1 down to 0).
REQ-009 SHALL have port i_start_st  input  ST_W  traceback start state (best-metric state), valid with the first step of a window.
REQ-010 SHALL have port o_busy  output  1  high while emitting; upstream holds steps while high.
REQ-011 SHALL have port o_bit  output  1  decoded bit, forward time order.
REQ-012 SHALL have port o_bit_vld  output  1  o_bit valid this cycle.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse with the last bit of a window.

Function
REQ-014 SHALL implement FSM IDLE -> TRACE -> EMIT -> IDLE; all transitions only when en_t=1.
REQ-015 IDLE: on i_bck_vld, SHALL load cur_st = i_start_st, process that step as in REQ-016, go TRACE, step count = 1.
REQ-016 Per accepted step SHALL push MSB of cur_st into a TB_DEPTH-entry LIFO, then cur_st <= i_bck_prv_st slice[cur_st].
REQ-017 TRACE: SHALL accept one step per cycle with i_bck_vld; cycles without i_bck_vld hold; after TB_DEPTH steps go EMIT.
REQ-018 EMIT: SHALL pop LIFO one bit per cycle, o_bit_vld=1, first bit = step 0; o_busy=1 throughout; o_done=1 with the TB_DEPTH-th bit; then IDLE.
REQ-019 i_bck_vld during EMIT SHALL be ignored (no capture, no state change).
REQ-020 i_start_st SHALL be sampled only on the first step of a window; changes afterwards have no effect.
REQ-021 Step counter SHALL be ceil(log2(TB_DEPTH+1)) bits, never wraps; LIFO pointer saturates at 0 and TB_DEPTH.
REQ-022 Latency: first o_bit SHALL appear the cycle after the TB_DEPTH-th step is accepted; window throughput TB_DEPTH capture + TB_DEPTH emit cycles.
REQ-023 en_t=0 mid-window SHALL freeze FSM, counters, LIFO; outputs hold except o_bit_vld and o_done forced 0.

Reset
REQ-024 On rst=1 SHALL asynchronously set FSM=IDLE, cur_st=0, counts=0, LIFO contents=0, o_bit=0, o_bit_vld=0, o_busy=0, o_done=0.
REQ-025 rst asserted mid-TRACE or mid-EMIT SHALL discard the partial window; no o_done for it.

Configuration
REQ-026 With VITERBI_TB_PAR_OUT_EN defined SHALL add outputs o_word (TB_DEPTH bits, bit i = step i) and o_word_vld (one-cycle pulse coincident with o_done), reset 0; without it these ports SHALL not exist and serial behaviour is unchanged.

Structure
REQ-027 NUM_ST, ST_W, TB_DEPTH defaults and the FSM state enum SHALL live in shared package viterbi_pkg, common with ACS and memory stages.
REQ-028 LIFO SHALL be a sub-module viterbi_lifo (push, pop, full, empty, async active-high reset).

Verification
REQ-029 All pointers 0, start 0, 8 steps -> o_bit 0,0,0,0,0,0,0,0; o_done on 8th bit.
REQ-030 All ptr[3]=3, start 3 -> 8 ones; PAR_OUT_EN: o_word=0xFF.
REQ-031 ptr[2]=1, ptr[1]=2 every step, start 2 -> o_bit 0,1,0,1,0,1,0,1; o_word=0xAA.
REQ-032 i_bck_vld gaps in TRACE plus en_t=0 for 3 cycles in EMIT -> same sequence as REQ-031, o_bit_vld low during freeze.
REQ-033 rst pulse after 5 steps, then fresh REQ-029 window -> only REQ-029 output, one o_done.
REQ-034 i_bck_vld held high in EMIT -> ignored; next window starts only from IDLE.
